// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced 3-to-8 decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // One-hot decode of a 3-bit code onto an 8-bit strobe.
  function automatic logic [7:0] onehot8(input logic [2:0] code);
    logic [7:0] v;
    v = 8'h01 << code;
    return v;
  endfunction

endpackage

// File: rtl/decoder_3to8_seq_hold_counter.sv
// 8-bit loadable down-counter with a zero flag; clear beats load beats decrement.
module hold_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [7:0] r_cnt;

  // Counter register: saturates at zero rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: accepts a code in IDLE, holds a one-hot strobe
// for HOLD_CYCLES, then forces an all-zero gap of GAP_CYCLES before the next accept.
module decoder_3to8_seq
  import decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,  // legal 1..255
  parameter int unsigned GAP_CYCLES  = 1   // legal 0..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,       // active-low enable; high aborts to IDLE
  input  logic [2:0] Y,
  input  logic       Valid,
  output logic       Ready,
  output logic [7:0] Out,
  output logic       Busy,
  output logic       Overrun
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     r_state;
  logic [2:0] r_code;
  logic [7:0] r_out;
  logic       r_overrun;

  logic       w_cnt_clr;
  logic       w_cnt_load;
  logic [7:0] w_cnt_load_val;
  logic       w_cnt_dec;
  logic       w_cnt_zero;

  hold_counter u_hold_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_cnt_clr),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Counter control: load on entry to HOLD/GAP, count down while in them.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_cnt_clr      = EN;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = HOLD_LOAD;
    w_cnt_dec      = 1'b0;
    if (!EN) begin
      case (r_state)
        IDLE: begin
          w_cnt_load = Valid;
        end
        HOLD: begin
          if (w_cnt_zero) begin
            w_cnt_load     = (GAP_CYCLES > 0);
            w_cnt_load_val = GAP_LOAD;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        GAP: begin
          w_cnt_dec = !w_cnt_zero;
        end
        default: begin
          w_cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // FSM with registered strobe and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_code    <= 3'd0;
      r_out     <= 8'h00;
      r_overrun <= 1'b0;
    end else if (EN) begin
      r_state   <= IDLE;
      r_out     <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Valid) begin
            r_code  <= Y;
            r_out   <= onehot8(Y);
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (Valid) r_overrun <= 1'b1;
          if (w_cnt_zero) begin
            r_out   <= 8'h00;
            r_state <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            // Re-derived from the latched code so Out can only ever show that one bit.
            r_out <= onehot8(r_code);
          end
        end
        GAP: begin
          if (Valid) r_overrun <= 1'b1;
          r_out <= 8'h00;
          if (w_cnt_zero) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_out   <= 8'h00;
        end
      endcase
    end
  end

  assign Ready   = (r_state == IDLE);
  assign Busy    = (r_state != IDLE);
  assign Out     = r_out;
  assign Overrun = r_overrun;

endmodule

// File: doc/decoder_3to8_seq.md
# decoder_3to8_seq

Sequenced 3-to-8 decoder that consumes the {Y, Done} output of the team's 8-to-3 priority encoder and drives a registered one-hot strobe for a programmable number of cycles, followed by a programmable idle gap. It sits on the return path of the encoder, for example re-driving a selected line or LED and acknowledging the request. It uses the same active-low enable convention as the encoder and adds a ready/valid handshake and an overrun flag.

## Interface
Parameters:
- HOLD_CYCLES, 4: cycles Out stays one-hot per accepted code; legal 1..255.
- GAP_CYCLES, 1: forced all-zero cycles after each hold; legal 0..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- EN  in  1  enable, active-low; EN=1 aborts and holds the block idle.
- Y  in  3  code to decode; 3'b000..3'b111 selects Out[0]..Out[7].
- Valid  in  1  code present; driven by the encoder's Done.
- Ready  out  1  block can accept a code this cycle.
- Out  out  8  registered one-hot output, or 8'h00 when not holding.
- Busy  out  1  high in HOLD or GAP.
- Overrun  out  1  sticky; a Valid arrived while Ready=0.

## Operation
- Three states: IDLE, HOLD, GAP. An 8-bit down-counter cnt and a 3-bit latched code.
- IDLE: Ready=1, Out=0. At an edge with EN=0, Valid=1: latch Y, load cnt=HOLD_CYCLES-1, go to HOLD.
- HOLD: Out=1<<code. If cnt≠0, decrement. At cnt=0: if GAP_CYCLES>0, load cnt=GAP_CYCLES-1 and go to GAP; otherwise go to IDLE.
- GAP: Out=0. If cnt≠0, decrement. At cnt=0, go to IDLE.
- Accept only in IDLE. A Valid=1 sampled with EN=0 in HOLD or GAP is dropped and sets Overrun.
- Y is ignored when Valid=0. Valid=1 with Y=0 is a legal request for Out[0].
- EN=1 at any edge: next state is IDLE, Out=0, cnt=0, and Overrun is cleared. EN=1 overrides Valid.
- Out is always zero or exactly one-hot. It never changes between two different one-hot values without at least one all-zero cycle.

## Timing
- Reset values: state=IDLE, Ready=1, Out=8'h00, Busy=0, Overrun=0, cnt=0, code=0.
- All outputs are registered (Ready and Busy decode the registered state).
- Latency: Valid accepted at edge k gives Out one-hot for cycles k+1 .. k+HOLD_CYCLES.
- After the hold, Out=0 and Busy=1 for GAP_CYCLES cycles. Ready returns at cycle k+HOLD_CYCLES+GAP_CYCLES+1.
- Maximum acceptance rate is one code per HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Edge where HOLD ends with Valid=1 and GAP=0: the code is not accepted, because Ready=0 in that cycle. Overrun is set.
- Reset asserted mid-HOLD: Out goes to 0 immediately (asynchronous). After release, the block is in IDLE.
- EN abort: Out=0 from the cycle after EN is sampled high.

## Structure
- Shared package decoder_pkg: state enum {IDLE, HOLD, GAP} and the function onehot8(code).
- One natural sub-module, hold_counter: 8-bit loadable down-counter with a zero flag.
- The FSM and output registers live in the top module.

## Test plan
- Reset, then EN=0, Valid=1, Y=3'b101 for 1 cycle (HOLD=4, GAP=1) -> Out=8'h20 for 4 cycles, then 8'h00; Ready high again 6 cycles after acceptance; Overrun=0.
- Valid=1, Y=3'b000 held continuously -> Out=8'h01 for 4 cycles, 1 gap cycle, then re-accept; Overrun=1 after the first busy cycle.
- EN=1 during HOLD with Y=3'b111 -> Out=8'h00 the next cycle; Ready=1; Overrun cleared; a following EN=0, Valid=1 is accepted normally.
- HOLD_CYCLES=1, GAP_CYCLES=0, Valid pulses every other cycle with Y=1,2,3 -> Out sequence 8'h02, 0, 8'h04, 0, 8'h08; no overrun.
- rst_n low mid-HOLD -> Out=8'h00 asynchronously; after release, Ready=1 and Busy=0.
- Sweep Y=0..7 with valid requests -> Out one-hot at bit Y each time; never two bits set; Valid=0 with Y changing -> Out stays 0.
